// File: rtl/timer_pwm_slave_n.sv
// Prescaled up-counter with double-buffered period/compare, N_CH PWM channels and W1C status.
// Register reads answer one cycle after the strobe; the bus never stalls.
module timer_pwm_slave_n #(
  parameter int CNT_W   = 16,
  parameter int N_CH    = 4,
  parameter int PRESC_W = 8
) (
  input  logic            i_Clk,
  input  logic            i_Rst,
  input  logic            i_WEnable,
  input  logic [31:0]     i_WAddr,
  input  logic [31:0]     i_WData,
  input  logic            i_REnable,
  input  logic [31:0]     i_RAddr,
  output logic [31:0]     o_RData,
  output logic            o_Err,
  output logic            o_Irq,
  output logic [N_CH-1:0] o_Pwm,
  output logic            o_Ovf
);
  localparam int FW = N_CH + 1;

  logic               en, arld;
  logic [PRESC_W-1:0] presc_cfg, presc;
  logic [CNT_W-1:0]   period_sh, period_act, cnt;
  logic [CNT_W-1:0]   cmp_sh  [N_CH];
  logic [CNT_W-1:0]   cmp_act [N_CH];
  logic [FW-1:0]      status, irq_en, flag_set, w1c;
  logic [N_CH-1:0]    ch_en, pol, wr_cmp;
  logic               wr_ok, rd_ok, tick, cnt_wr, wrap;
  logic [31:0]        rd_val;
  logic               unused_wdata;

  assign unused_wdata = ^i_WData;
  assign tick   = en && (presc == presc_cfg);
  assign cnt_wr = i_WEnable && (i_WAddr == 32'd2);
  // A COUNT write pre-empts any tick in the same cycle, so no wrap or compare hit.
  assign wrap   = tick && !cnt_wr && (cnt == period_act);
  assign w1c    = (i_WEnable && (i_WAddr == 32'd3)) ? i_WData[FW-1:0] : '0;
  assign o_Irq  = |(status & irq_en);

  always_comb begin
    wr_ok  = (i_WAddr < 32'd6);
    wr_cmp = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (i_WAddr == 32'(8 + k)) begin
        wr_ok     = 1'b1;
        wr_cmp[k] = 1'b1;
      end
    end
  end

  always_comb begin
    flag_set    = '0;
    flag_set[0] = wrap;
    for (int k = 0; k < N_CH; k++) begin
      flag_set[k+1] = tick && !cnt_wr && (cnt == cmp_act[k]);
    end
  end

  always_comb begin
    rd_val = '0;
    rd_ok  = 1'b1;
    case (i_RAddr)
      32'd0: begin
        rd_val[0]            = en;
        rd_val[1]            = arld;
        rd_val[16 +: PRESC_W] = presc_cfg;
      end
      32'd1: rd_val[CNT_W-1:0] = period_sh;
      32'd2: rd_val[CNT_W-1:0] = cnt;
      32'd3: rd_val[FW-1:0]    = status;
      32'd4: rd_val[FW-1:0]    = irq_en;
      32'd5: begin
        rd_val[N_CH-1:0]  = ch_en;
        rd_val[8 +: N_CH] = pol;
      end
      default: begin
        rd_ok = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
          if (i_RAddr == 32'(8 + k)) begin
            rd_ok              = 1'b1;
            rd_val[CNT_W-1:0]  = cmp_sh[k];
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      en <= 1'b0;  arld <= 1'b0;  presc_cfg <= '0;  presc <= '0;
      period_sh <= '0;  period_act <= '0;  cnt <= '0;
      status <= '0;  irq_en <= '0;  ch_en <= '0;  pol <= '0;
      o_RData <= '0;  o_Err <= 1'b0;  o_Pwm <= '0;  o_Ovf <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        cmp_sh[k]  <= '0;
        cmp_act[k] <= '0;
      end
    end else begin
      if (i_WEnable) begin
        o_Err <= !wr_ok;
      end else if (i_REnable) begin
        o_Err <= !rd_ok;
        if (rd_ok) o_RData <= rd_val;
      end

      if (cnt_wr) begin
        cnt   <= i_WData[CNT_W-1:0];
        presc <= '0;
      end else if (!en) begin
        presc <= '0;
      end else begin
        presc <= tick ? '0 : presc + PRESC_W'(1);
        if (wrap)      cnt <= '0;
        else if (tick) cnt <= cnt + CNT_W'(1);
      end

      // Idle timers track the shadows; running timers only reload at the wrap.
      if (!en || wrap) begin
        period_act <= period_sh;
        for (int k = 0; k < N_CH; k++) cmp_act[k] <= cmp_sh[k];
      end
      if (wrap && !arld) en <= 1'b0;

      o_Ovf  <= wrap;
      status <= (status & ~w1c) | flag_set;
      for (int k = 0; k < N_CH; k++) begin
        o_Pwm[k] <= (ch_en[k] && (cnt < cmp_act[k])) ^ pol[k];
      end

      if (i_WEnable) begin
        case (i_WAddr)
          32'd0: begin
            en        <= i_WData[0];
            arld      <= i_WData[1];
            presc_cfg <= i_WData[16 +: PRESC_W];
          end
          32'd1: period_sh <= i_WData[CNT_W-1:0];
          32'd4: irq_en    <= i_WData[FW-1:0];
          32'd5: begin
            ch_en <= i_WData[N_CH-1:0];
            pol   <= i_WData[8 +: N_CH];
          end
          default: ;
        endcase
        for (int k = 0; k < N_CH; k++) begin
          if (wr_cmp[k]) cmp_sh[k] <= i_WData[CNT_W-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_timer_pwm_slave_n.sv
// Randomised scoreboard bench for timer_pwm_slave_n: a per-cycle reference model queues
// the expected outputs, and a monitor on the falling edge pops and compares them.
module tb_timer_pwm_slave_n;
  localparam int NC = 4;
  localparam logic [31:0] CMASK  = 32'h0000_FFFF;
  localparam logic [31:0] PMASK  = 32'h0000_00FF;
  localparam logic [31:0] FMASK  = 32'h0000_001F;
  localparam logic [31:0] CHMASK = 32'h0000_000F;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wen = 1'b0, ren = 1'b0;
  logic [31:0]   waddr = '0, wdata = '0, raddr = '0;
  logic [31:0]   rdata;
  logic          err, irq, ovf;
  logic [NC-1:0] pwm;

  timer_pwm_slave_n #(.CNT_W(16), .N_CH(NC), .PRESC_W(8)) dut (
    .i_Clk(clk), .i_Rst(rst),
    .i_WEnable(wen), .i_WAddr(waddr), .i_WData(wdata),
    .i_REnable(ren), .i_RAddr(raddr),
    .o_RData(rdata), .o_Err(err), .o_Irq(irq), .o_Pwm(pwm), .o_Ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]   rdata;
    logic          err;
    logic          irq;
    logic          ovf;
    logic [NC-1:0] pwm;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_new, e_got;
  int   n_cmp = 0, n_bad = 0, cyc = 0;

  // Reference model state (plain words, masked to register widths).
  logic        m_en, m_arld, m_err, m_ovf;
  logic [31:0] m_presc, m_pc, m_psh, m_pact, m_cnt, m_status, m_irqen, m_chen, m_pol, m_rdata, m_pwm;
  logic [31:0] m_csh  [NC];
  logic [31:0] m_cact [NC];
  logic        t_tick, t_cw, t_wrap;
  logic [31:0] t_set, t_pwm, t_w1c;

  function automatic logic addr_ok(input logic [31:0] a);
    return (a < 32'd6) || ((a >= 32'd8) && (a < 32'(8 + NC)));
  endfunction

  function automatic logic [31:0] reg_val(input logic [31:0] a);
    logic [31:0] v;
    v = 32'd0;
    case (a)
      32'd0: v = (m_presc << 16) | {30'd0, m_arld, m_en};
      32'd1: v = m_psh;
      32'd2: v = m_cnt;
      32'd3: v = m_status;
      32'd4: v = m_irqen;
      32'd5: v = (m_pol << 8) | m_chen;
      default: for (int k = 0; k < NC; k++) if (a == 32'(8 + k)) v = m_csh[k];
    endcase
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_en = 1'b0; m_arld = 1'b0; m_err = 1'b0; m_ovf = 1'b0;
      m_presc = '0; m_pc = '0; m_psh = '0; m_pact = '0; m_cnt = '0;
      m_status = '0; m_irqen = '0; m_chen = '0; m_pol = '0; m_rdata = '0; m_pwm = '0;
      for (int k = 0; k < NC; k++) begin m_csh[k] = '0; m_cact[k] = '0; end
    end else begin
      t_tick = m_en && (m_pc == m_presc);
      t_cw   = wen && (waddr == 32'd2);
      t_wrap = t_tick && !t_cw && (m_cnt == m_pact);
      t_set  = {31'd0, t_wrap};
      t_pwm  = 32'd0;
      for (int k = 0; k < NC; k++) begin
        if (t_tick && !t_cw && (m_cnt == m_cact[k])) t_set = t_set | (32'd1 << (k + 1));
        if (m_chen[k] && (m_cnt < m_cact[k]))         t_pwm = t_pwm | (32'd1 << k);
      end
      t_pwm = t_pwm ^ m_pol;

      if (wen) m_err = !addr_ok(waddr);
      else if (ren) begin
        if (addr_ok(raddr)) begin m_rdata = reg_val(raddr); m_err = 1'b0; end
        else m_err = 1'b1;
      end

      if (!m_en || t_wrap) begin
        m_pact = m_psh;
        for (int k = 0; k < NC; k++) m_cact[k] = m_csh[k];
      end
      if (t_cw)        m_cnt = wdata & CMASK;
      else if (t_tick) m_cnt = t_wrap ? 32'd0 : ((m_cnt + 32'd1) & CMASK);
      m_pc  = (!m_en || t_tick || t_cw) ? 32'd0 : ((m_pc + 32'd1) & PMASK);
      m_ovf = t_wrap;
      if (t_wrap && !m_arld) m_en = 1'b0;
      t_w1c    = (wen && (waddr == 32'd3)) ? wdata : 32'd0;
      m_status = ((m_status & ~t_w1c) | t_set) & FMASK;
      m_pwm    = t_pwm;

      if (wen) begin
        case (waddr)
          32'd0: begin m_en = wdata[0]; m_arld = wdata[1]; m_presc = (wdata >> 16) & PMASK; end
          32'd1: m_psh = wdata & CMASK;
          32'd4: m_irqen = wdata & FMASK;
          32'd5: begin m_chen = wdata & CHMASK; m_pol = (wdata >> 8) & CHMASK; end
          default: for (int k = 0; k < NC; k++) if (waddr == 32'(8 + k)) m_csh[k] = wdata & CMASK;
        endcase
      end
    end
    e_new.rdata = m_rdata;
    e_new.err   = m_err;
    e_new.irq   = |(m_status & m_irqen);
    e_new.ovf   = m_ovf;
    e_new.pwm   = m_pwm[NC-1:0];
    exp_q.push_back(e_new);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, want %h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_empty at cycle %0d: got no entry, want one", cyc);
    end else begin
      e_got = exp_q.pop_front();
      chk("rdata", rdata, e_got.rdata);
      chk("err", 32'(err), 32'(e_got.err));
      chk("irq", 32'(irq), 32'(e_got.irq));
      chk("ovf", 32'(ovf), 32'(e_got.ovf));
      chk("pwm", 32'(pwm), 32'(e_got.pwm));
    end
  end

  task automatic drive(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                       input logic re, input logic [31:0] ra);
    @(negedge clk);
    rst = 1'b0; wen = we; waddr = wa; wdata = wd; ren = re; raddr = ra;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d); drive(1'b1, a, d, 1'b0, 32'd0); endtask
  task automatic rd(input logic [31:0] a); drive(1'b0, 32'd0, 32'd0, 1'b1, a); endtask
  task automatic idle(input int n); repeat (n) drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0); endtask
  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; wen = 1'b0; ren = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  logic [31:0] addr_tab [16] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7,
                                 32'd8, 32'd9, 32'd10, 32'd11, 32'd12, 32'd15, 32'h108, 32'hFFFF_FFFF};

  function automatic logic [31:0] rand_data(input logic [31:0] a);
    logic [31:0] d;
    d = $urandom;
    case (a)
      32'd0: begin
        d        = d & 32'hFF00_FFFC;
        d[17:16] = 2'($urandom_range(0, 2));
        d[1]     = ($urandom_range(0, 3) != 0);
        d[0]     = ($urandom_range(0, 4) != 0);
      end
      32'd1, 32'd2:                  d = (d & 32'hFFFF_0000) | $urandom_range(0, 12);
      32'd8, 32'd9, 32'd10, 32'd11:  d = (d & 32'hFFFF_0000) | $urandom_range(0, 14);
      default: ;
    endcase
    return d;
  endfunction

  initial begin
    logic [31:0] a, b;
    int r;
    do_reset(3);
    for (int i = 0; i < 12; i++) rd(32'(i));   // includes unmapped 6, 7
    rd(32'd1);
    rd(32'd6);

    // Auto-reload, PRESC=1, PERIOD=4: one wrap every 10 cycles; W1C and IRQ.
    wr(32'd1, 32'd4);
    wr(32'd0, 32'h0001_0003);
    idle(30);
    rd(32'd3);
    wr(32'd3, 32'd1);
    rd(32'd3);
    wr(32'd4, 32'd1);
    idle(25);
    wr(32'd3, 32'd1);
    idle(3);

    // PWM on channel 0, then inverted polarity, then CMP0=0.
    wr(32'd0, 32'd0);
    wr(32'd2, 32'd0);
    wr(32'd1, 32'd4);
    wr(32'd8, 32'd2);
    wr(32'd5, 32'd1);
    wr(32'd0, 32'd3);
    idle(15);
    wr(32'd5, 32'h0000_0101);
    idle(10);
    wr(32'd5, 32'd1);
    wr(32'd8, 32'd0);
    idle(12);

    // Period change while running waits for the next wrap.
    wr(32'd8, 32'd2);
    wr(32'd1, 32'd9);
    rd(32'd1);
    idle(25);

    // One-shot with PERIOD=3; W1C of OVF lands on the wrap cycle.
    wr(32'd0, 32'd0);
    idle(2);
    wr(32'd2, 32'd0);
    wr(32'd1, 32'd3);
    wr(32'd0, 32'd1);
    idle(3);
    wr(32'd3, 32'd1);
    rd(32'd3);
    rd(32'd0);
    idle(5);
    rd(32'd2);

    // Reset mid-period, then simultaneous write and read.
    wr(32'd1, 32'd9);
    wr(32'd8, 32'd7);
    wr(32'd5, 32'd1);
    wr(32'd0, 32'd3);
    idle(3);
    do_reset(1);
    rd(32'd0);
    rd(32'd2);
    drive(1'b1, 32'd1, 32'd5, 1'b1, 32'd1);
    rd(32'd1);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199);
      a = addr_tab[$urandom_range(0, 15)];
      b = addr_tab[$urandom_range(0, 15)];
      if (r < 1)        do_reset(1);
      else if (r < 45)  wr(a, rand_data(a));
      else if (r < 85)  rd(b);
      else if (r < 95)  drive(1'b1, a, rand_data(a), 1'b1, b);
      else              idle(1);
    end

    idle(5);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/timer_pwm_slave_n.md
Name: timer_pwm_slave_n

Overview:
- Parametrised successor to the SoC's fixed 4-channel timer bus slave.
- Provides a CNT_W-bit up-counter with prescaler, auto-reload or one-shot operation, and N_CH PWM/compare channels.
- Period and compare values are double-buffered; each channel has its own output polarity.
- Status flags are write-1-to-clear, with a maskable interrupt output. The block sits on the same simple register bus as the other VeSPA peripherals.

Parameters:
CNT_W, 16, counter/period/compare width (1..32)
N_CH, 4, number of PWM/compare channels (1..8)
PRESC_W, 8, prescaler width (1..16)

Ports:
i_Clk  in  1  clock
i_Rst  in  1  reset: synchronous, active-high, on clock i_Clk
i_WEnable  in  1  write strobe
i_WAddr  in  32  write word address
i_WData  in  32  write data
i_REnable  in  1  read strobe
i_RAddr  in  32  read word address
o_RData  out  32  read data, registered
o_Err  out  1  access error, registered
o_Irq  out  1  level interrupt = |(STATUS & IRQ_EN)
o_Pwm  out  N_CH  PWM outputs, bit k = channel k
o_Ovf  out  1  one-cycle pulse on counter wrap

Behaviour:
Register map (full 32-bit address decode, word index):
- 0 CTRL R/W: [0] EN, [1] ARLD, [16+:PRESC_W] PRESC.
- 1 PERIOD R/W: shadow value.
- 2 COUNT R/W: a write loads the counter and clears the prescaler.
- 3 STATUS R/W1C: [0] OVF, [1+k] CMPk.
- 4 IRQ_EN R/W: same bit layout as STATUS.
- 5 CHCFG R/W: [k] CH_EN, [8+k] POL.
- 8+k CMPk R/W: shadow value, k<N_CH.
- Unused bits read 0.

Bus rules:
- Read latency 1 cycle; o_RData and o_Err update the cycle after the strobe.
- o_RData holds its value otherwise.
- Write and read in the same cycle: the write is performed, the read is ignored, o_RData holds.
- Unmapped address, or CMPk with k>=N_CH: o_Err=1 for that access and no state changes. A valid access sets o_Err=0.
- Reading a shadowed register returns the shadow value.
- Writes take effect on the next edge.

Reset:
- All registers, counter, prescaler, active copies, o_RData, o_Err, o_Ovf and flags are 0.
- o_Pwm = POL = 0.
- Reset mid-operation aborts immediately with no completion of the current period.

Counting:
- With EN=1, the prescaler counts 0..PRESC; tick = (presc==PRESC). PRESC=0 gives a tick every cycle.
- On tick with cnt != PERIOD_act: cnt += 1.
- On tick with cnt == PERIOD_act:
  - cnt <= 0 and o_Ovf pulses for 1 cycle.
  - OVF flag is set.
  - Active PERIOD and CMPs are loaded from the shadows.
  - If ARLD=0, EN is cleared (one-shot). EN reads 0 afterwards and the counter holds at 0.
- PERIOD_act = 0: overflow on every tick.
- With EN=0: the prescaler is held at 0, cnt holds, and the shadows copy to active every cycle.
- Arithmetic is unsigned CNT_W; values wider than CNT_W are truncated on write.

Compare/PWM:
- On tick, if cnt == CMPk_act, set flag CMPk.
- o_Pwm[k] is registered and equals CH_EN[k] & (cnt < CMPk_act), XOR POL[k].
- CMP=0 gives a constantly inactive level; CMP > PERIOD gives a constantly active level.
- CH_EN[k]=0 forces o_Pwm[k] = POL[k].

Flags:
- A hardware set beats a W1C clear in the same cycle (flag stays 1).
- o_Irq is combinational from the registered STATUS and IRQ_EN.

Simultaneous events:
- A COUNT write in the same cycle as a tick: the write wins and no overflow occurs that cycle.
- A CTRL write clearing EN on a wrap cycle: the wrap completes, then the block stops.

Test Plan:
- Reset, then read all registers → all return 0 with o_Err=0; o_Pwm=0; read address 6 → o_Err=1 and o_RData unchanged.
- PERIOD=4, PRESC=1, ARLD=1, EN=1 → o_Ovf pulses every 10 cycles; STATUS reads 1; write STATUS=1 → 0; IRQ_EN=1 → o_Irq follows the flag.
- N_CH=4, CMP0=2, CH_EN=1, PERIOD=4, PRESC=0 → o_Pwm[0] high 2 of every 5 cycles; POL0=1 gives the inverted pattern; CMP0=0 → constant low.
- While running, write PERIOD=9 → the old period of 4 completes, and the new 10-cycle period starts only after the next wrap; PERIOD read returns 9 immediately.
- ARLD=0, PERIOD=3 → a single wrap occurs, then CTRL reads EN=0 and cnt stays 0; W1C of OVF in the same cycle as the hardware set → flag reads 1.
- Assert i_Rst mid-period with cnt=3 → next cycle cnt=0, o_Pwm=0, CTRL=0; assert write and read in the same cycle → write applied, o_RData unchanged.
